// File: rtl/lipsi_pkg.sv
// lipsi_pkg: shared definitions for the parametrised Lipsi accumulator core.
//   - state_e    : FSM states (FETCH, EXEC, IND, HALT)
//   - alu_op_e   : ALU operation codes (the fff instruction field)
//   - BR_*       : branch condition codes (the cc instruction field)
//   - SHF_*      : shift sub-op codes (the ss field, used when LIPSI_SHIFT_EN is defined)
//   - opcode-nibble constants and HALT_OP
package lipsi_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    IND   = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_ADC = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_LD  = 3'd7
  } alu_op_e;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_C      = 2'b01;
  localparam logic [1:0] BR_Z      = 2'b10;
  localparam logic [1:0] BR_NZ     = 2'b11;

  localparam logic [1:0] SHF_SHL = 2'b00;
  localparam logic [1:0] SHF_SHR = 2'b01;
  localparam logic [1:0] SHF_ROL = 2'b10;
  localparam logic [1:0] SHF_ROR = 2'b11;

  localparam logic [3:0] ALU_IMM = 4'hC;
  localparam logic [3:0] BR      = 4'hD;
  localparam logic [3:0] ST      = 4'h8;
  localparam logic [3:0] LDI     = 4'hA;
  localparam logic [3:0] STI     = 4'hB;
  localparam logic [3:0] SHF     = 4'hE;

  localparam logic [7:0] HALT_OP = 8'hFF;

endpackage

// File: rtl/lipsi_core_p_alu.sv
// lipsi_alu: combinational ALU of the Lipsi core.
//   a      : accumulator operand
//   b      : memory or immediate operand
//   cin    : current carry flag
//   fff    : operation (alu_op_e)
//   result : new accumulator value (modulo 2**DATA_W)
//   cout   : new carry flag; carry-out for ADD/ADC, borrow for SUB/SBC,
//            cin passed through unchanged for the logic ops and LD
module lipsi_alu
  import lipsi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  alu_op_e           fff,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  // One extra bit catches the carry-out on addition; on subtraction the
  // extra bit goes to 1 exactly when the unsigned result underflows.
  logic [DATA_W:0] wide;
  logic [DATA_W:0] cin_w;

  always_comb begin
    wide   = '0;
    cin_w  = (DATA_W+1)'(cin);
    result = a;
    cout   = cin;
    unique case (fff)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        cout   = wide[DATA_W];
      end
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        cout   = wide[DATA_W];
      end
      ALU_ADC: begin
        wide   = {1'b0, a} + {1'b0, b} + cin_w;
        result = wide[DATA_W-1:0];
        cout   = wide[DATA_W];
      end
      ALU_SBC: begin
        wide   = {1'b0, a} - {1'b0, b} - cin_w;
        result = wide[DATA_W-1:0];
        cout   = wide[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_LD:  result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/lipsi_core_p.sv
// lipsi_core_p: parametrised multi-cycle Lipsi accumulator processor.
//
// Optional feature macro: LIPSI_SHIFT_EN. When defined, opcode 1110 00ss
// performs SHL/SHR/ROL/ROR on the accumulator; when undefined every 1110 xxxx
// instruction is a NOP that leaves A and C untouched.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   run        1 = FSM advances, 0 = all state (pc, A, C, memory, FSM) held
//   imem_addr  instruction fetch address (always equal to pc)
//   imem_data  instruction byte at imem_addr, combinational
//   acc        accumulator A
//   carry      carry flag C
//   pc_o       program counter
//   halted     high while in HALT
//   retire     one-cycle pulse in the cycle an instruction completes
//
// Timing: FETCH takes one cycle; EXEC one more; indirect ops add IND.
// Immediate and branch operands are read from imem_data during EXEC, where
// pc already points at the operand byte.
module lipsi_core_p
  import lipsi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_data,
  output logic [DATA_W-1:0]  acc,
  output logic               carry,
  output logic [IMEM_AW-1:0] pc_o,
  output logic               halted,
  output logic               retire
);

  state_e              state_q, state_d;
  logic [IMEM_AW-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                c_q, c_d;
  logic [7:0]          ir_q, ir_d;
  logic [DMEM_AW-1:0]  ptr_q, ptr_d;

  // Data memory is deliberately not reset.
  logic [DATA_W-1:0]   dmem_q [2**DMEM_AW];
  logic                dmem_we;
  logic [DMEM_AW-1:0]  dmem_waddr;

  logic [DMEM_AW-1:0]  r_addr;
  logic [DATA_W-1:0]   dmem_rd;
  logic [DATA_W-1:0]   alu_b;
  alu_op_e             alu_fff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cout;
  logic                br_taken;

  // Direct register field only reaches dmem[0..15].
  assign r_addr  = DMEM_AW'(ir_q[3:0]);
  assign dmem_rd = dmem_q[r_addr];

  // ALU reg (0fff rrrr) takes fff from [6:4] and a memory operand;
  // ALU imm (1100 0fff) takes fff from [2:0] and the byte after the opcode.
  assign alu_fff = alu_op_e'(ir_q[7] ? ir_q[2:0] : ir_q[6:4]);
  assign alu_b   = ir_q[7] ? DATA_W'(imem_data) : dmem_rd;

  lipsi_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .cin    (c_q),
    .fff    (alu_fff),
    .result (alu_res),
    .cout   (alu_cout)
  );

  always_comb begin
    br_taken = 1'b0;
    unique case (ir_q[1:0])
      BR_ALWAYS: br_taken = 1'b1;
      BR_C:      br_taken = c_q;
      BR_Z:      br_taken = (a_q == '0);
      BR_NZ:     br_taken = (a_q != '0);
      default:   br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    c_d        = c_q;
    ir_d       = ir_q;
    ptr_d      = ptr_q;
    dmem_we    = 1'b0;
    dmem_waddr = r_addr;
    retire     = 1'b0;

    if (run) begin
      unique case (state_q)
        FETCH: begin
          if (imem_data == HALT_OP) begin
            state_d = HALT;
          end else begin
            ir_d    = imem_data;
            pc_d    = pc_q + 1'b1;
            state_d = EXEC;
          end
        end

        EXEC: begin
          state_d = FETCH;
          retire  = 1'b1;
          if (!ir_q[7]) begin
            a_d = alu_res;
            c_d = alu_cout;
          end else begin
            unique case (ir_q[7:4])
              ST: begin
                dmem_we    = 1'b1;
                dmem_waddr = r_addr;
              end
              LDI, STI: begin
                ptr_d   = dmem_rd[DMEM_AW-1:0];
                state_d = IND;
                retire  = 1'b0;
              end
              ALU_IMM: begin
                if (!ir_q[3]) begin
                  a_d  = alu_res;
                  c_d  = alu_cout;
                  pc_d = pc_q + 1'b1;
                end
              end
              BR: begin
                if (ir_q[3:2] == 2'b00) begin
                  pc_d = br_taken ? IMEM_AW'(imem_data) : pc_q + 1'b1;
                end
              end
`ifdef LIPSI_SHIFT_EN
              SHF: begin
                if (ir_q[3:2] == 2'b00) begin
                  unique case (ir_q[1:0])
                    SHF_SHL: begin
                      c_d = a_q[DATA_W-1];
                      a_d = {a_q[DATA_W-2:0], 1'b0};
                    end
                    SHF_SHR: begin
                      c_d = a_q[0];
                      a_d = {1'b0, a_q[DATA_W-1:1]};
                    end
                    SHF_ROL: begin
                      c_d = a_q[DATA_W-1];
                      a_d = {a_q[DATA_W-2:0], c_q};
                    end
                    SHF_ROR: begin
                      c_d = a_q[0];
                      a_d = {c_q, a_q[DATA_W-1:1]};
                    end
                    default: ;
                  endcase
                end
              end
`endif
              default: ;
            endcase
          end
        end

        IND: begin
          // ir[4] distinguishes STI (1011) from LDI (1010).
          if (ir_q[4]) begin
            dmem_we    = 1'b1;
            dmem_waddr = ptr_q;
          end else begin
            a_d = dmem_q[ptr_q];
          end
          retire  = 1'b1;
          state_d = FETCH;
        end

        HALT: ;

        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      ir_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
      ptr_q   <= ptr_d;
    end
  end

  // Writes only happen from EXEC/IND, which reset forces away from.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem_q[dmem_waddr] <= a_q;
    end
  end

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign acc       = a_q;
  assign carry     = c_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_lipsi_core_p.sv
// tb_lipsi_core_p: directed-program bench for lipsi_core_p.
// Two instances (DATA_W=8 and DATA_W=16) share clock, reset and run; sel16
// picks which one the monitor watches. Each retire is followed, one cycle
// later, by a comparison of {pc, C, A} against the next queued expectation.
module tb_lipsi_core_p;

  logic        clk;
  logic        reset;
  logic        run;
  bit          sel16;

  logic [7:0]  imem_addr8, imem_data8, pc8;
  logic [7:0]  acc8;
  logic        carry8, halted8, retire8;

  logic [7:0]  imem_addr16, imem_data16, pc16;
  logic [15:0] acc16;
  logic        carry16, halted16, retire16;

  logic [7:0]  mem8  [256];
  logic [7:0]  mem16 [256];
  logic [7:0]  pq [$];

  logic [24:0] exp_q [$];
  int          checks;
  int          errors;
  int          retire_cnt;
  bit          pending;

  logic [15:0] m_acc;
  logic [7:0]  m_pc, m_addr;
  logic        m_carry, m_halted, m_retire;

  assign imem_data8  = mem8[imem_addr8];
  assign imem_data16 = mem16[imem_addr16];

  assign m_acc    = sel16 ? acc16 : {8'h00, acc8};
  assign m_pc     = sel16 ? pc16 : pc8;
  assign m_addr   = sel16 ? imem_addr16 : imem_addr8;
  assign m_carry  = sel16 ? carry16 : carry8;
  assign m_halted = sel16 ? halted16 : halted8;
  assign m_retire = sel16 ? retire16 : retire8;

  lipsi_core_p #(.DATA_W(8), .IMEM_AW(8), .DMEM_AW(4)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .imem_addr (imem_addr8),
    .imem_data (imem_data8),
    .acc       (acc8),
    .carry     (carry8),
    .pc_o      (pc8),
    .halted    (halted8),
    .retire    (retire8)
  );

  lipsi_core_p #(.DATA_W(16), .IMEM_AW(8), .DMEM_AW(4)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .imem_addr (imem_addr16),
    .imem_data (imem_data16),
    .acc       (acc16),
    .carry     (carry16),
    .pc_o      (pc16),
    .halted    (halted16),
    .retire    (retire16)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] ex(input int pc, input bit c, input int a);
    logic [31:0] pcv, av;
    pcv = pc;
    av  = a;
    return {pcv[7:0], c, av[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start(input bit s16);
    reset = 1'b1;
    run   = 1'b1;
    @(posedge clk); #1;
    sel16 = s16;
    for (int i = 0; i < 256; i++) begin
      mem8[i]  = 8'hFF;
      mem16[i] = 8'hFF;
    end
    for (int i = 0; i < pq.size(); i++) begin
      if (s16) mem16[i] = pq[i];
      else     mem8[i]  = pq[i];
    end
    retire_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Counts rising edges after reset release until halted is seen.
  task automatic run_until_halt(input string name, input int max, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!m_halted && cyc < max) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({name, "_halted"}, 32'(m_halted), 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [24:0] e;
    logic [24:0] obs;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        obs = {m_pc, m_carry, m_acc};
        if (exp_q.size() == 0) begin
          check("retire_unexpected", 32'(obs), 32'h1FFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("retire_pc_c_a", 32'(obs), 32'(e));
        end
      end
      if (m_retire) begin
        pending = 1'b1;
        retire_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  cyc;
    bit  stall_ok;
    checks  = 0;
    errors  = 0;
    pending = 1'b0;
    sel16   = 1'b0;
    reset   = 1'b1;
    run     = 1'b1;

    // Immediate: C7 0A C0 05 FF
    pq = '{8'hC7, 8'h0A, 8'hC0, 8'h05, 8'hFF};
    exp_q.push_back(ex(2, 0, 'h0A));
    exp_q.push_back(ex(4, 0, 'h0F));
    start(1'b0);
    run_until_halt("imm", 40, cyc);
    check("imm_cycles", 32'(cyc), 32'd5);
    check("imm_acc", 32'(m_acc), 32'd15);
    check("imm_retires", 32'(retire_cnt), 32'd2);
    repeat (3) @(negedge clk);
    check("imm_pc_held", 32'(m_pc), 32'd4);
    check("imm_halt_held", 32'(m_halted), 32'd1);
    check("imm_queue_empty", 32'(exp_q.size()), 32'd0);

    // Carry: C7 F0 C0 20 C2 00
    pq = '{8'hC7, 8'hF0, 8'hC0, 8'h20, 8'hC2, 8'h00};
    exp_q.push_back(ex(2, 0, 'hF0));
    exp_q.push_back(ex(4, 1, 'h10));
    exp_q.push_back(ex(6, 0, 'h11));
    start(1'b0);
    run_until_halt("carry", 40, cyc);
    check("carry_cycles", 32'(cyc), 32'd7);
    check("carry_queue_empty", 32'(exp_q.size()), 32'd0);

    // Shift opcode E0 after setting C=1: NOP by default, SHL when enabled.
    pq = '{8'hC7, 8'hF0, 8'hC0, 8'h20, 8'hE0};
    exp_q.push_back(ex(2, 0, 'hF0));
    exp_q.push_back(ex(4, 1, 'h10));
`ifdef LIPSI_SHIFT_EN
    exp_q.push_back(ex(5, 0, 'h20));
`else
    exp_q.push_back(ex(5, 1, 'h10));
`endif
    start(1'b0);
    run_until_halt("shf", 40, cyc);
    check("shf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Loop: C7 03 C1 01 D3 02 FF
    pq = '{8'hC7, 8'h03, 8'hC1, 8'h01, 8'hD3, 8'h02, 8'hFF};
    exp_q.push_back(ex(2, 0, 3));
    exp_q.push_back(ex(4, 0, 2));
    exp_q.push_back(ex(2, 0, 2));
    exp_q.push_back(ex(4, 0, 1));
    exp_q.push_back(ex(2, 0, 1));
    exp_q.push_back(ex(4, 0, 0));
    exp_q.push_back(ex(6, 0, 0));
    start(1'b0);
    run_until_halt("loop", 60, cyc);
    check("loop_cycles", 32'(cyc), 32'd15);
    check("loop_acc", 32'(m_acc), 32'd0);
    check("loop_carry", 32'(m_carry), 32'd0);
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Indirect: C7 05 82 C7 AA B2 C7 00 A2 FF
    pq = '{8'hC7, 8'h05, 8'h82, 8'hC7, 8'hAA, 8'hB2, 8'hC7, 8'h00, 8'hA2, 8'hFF};
    exp_q.push_back(ex(2, 0, 'h05));
    exp_q.push_back(ex(3, 0, 'h05));
    exp_q.push_back(ex(5, 0, 'hAA));
    exp_q.push_back(ex(6, 0, 'hAA));
    exp_q.push_back(ex(8, 0, 'h00));
    exp_q.push_back(ex(9, 0, 'hAA));
    start(1'b0);
    run_until_halt("ind", 60, cyc);
    check("ind_cycles", 32'(cyc), 32'd15);
    check("ind_acc", 32'(m_acc), 32'hAA);
    check("ind_queue_empty", 32'(exp_q.size()), 32'd0);

    // ALU reg ops: C7 33 83 C7 10 03 63 13 13 13 FF
    pq = '{8'hC7, 8'h33, 8'h83, 8'hC7, 8'h10, 8'h03, 8'h63, 8'h13, 8'h13, 8'h13, 8'hFF};
    exp_q.push_back(ex(2, 0, 'h33));
    exp_q.push_back(ex(3, 0, 'h33));
    exp_q.push_back(ex(5, 0, 'h10));
    exp_q.push_back(ex(6, 0, 'h43));
    exp_q.push_back(ex(7, 0, 'h70));
    exp_q.push_back(ex(8, 0, 'h3D));
    exp_q.push_back(ex(9, 0, 'h0A));
    exp_q.push_back(ex(10, 1, 'hD7));
    start(1'b0);
    run_until_halt("reg", 60, cyc);
    check("reg_cycles", 32'(cyc), 32'd17);
    check("reg_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stall + width (DATA_W=16): C7 FF C0 01, run=0 between C0 and its operand.
    pq = '{8'hC7, 8'hFF, 8'hC0, 8'h01};
    exp_q.push_back(ex(2, 0, 'h00FF));
    exp_q.push_back(ex(4, 0, 'h0100));
    start(1'b1);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    stall_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_retire || m_acc != 16'h00FF || m_pc != 8'd3 || m_addr != 8'd3 ||
          m_carry || m_halted)
        stall_ok = 1'b0;
    end
    check("stall_hold", 32'(stall_ok), 32'd1);
    run = 1'b1;
    run_until_halt("stall", 40, cyc);
    check("stall_acc", 32'(m_acc), 32'h0100);
    check("stall_carry", 32'(m_carry), 32'd0);
    check("stall_pc", 32'(m_pc), 32'd4);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-EXEC of the second C7 0A.
    pq = '{8'hC7, 8'h0A, 8'hC7, 8'h0A};
    exp_q.push_back(ex(2, 0, 'h0A));
    start(1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_acc", 32'(m_acc), 32'd0);
    check("rst_carry", 32'(m_carry), 32'd0);
    check("rst_pc", 32'(m_pc), 32'd0);
    check("rst_halted", 32'(m_halted), 32'd0);
    check("rst_retire", 32'(m_retire), 32'd0);
    check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(ex(2, 0, 'h0A));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_fetch_addr", 32'(m_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_first_fetch_pc", 32'(m_pc), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_requeue_empty", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
